// File: rtl/seg_scan_mux.sv
// seg_scan_mux: time-multiplexed seven-segment display driver.
//
// A refresh prescaler walks a slot index across NUM_DIGITS active-low anodes.
// Each slot starts with BLANK_CYC cycles of all anodes off, which hides the
// segment transition between digits (anti-ghosting). All pin drives are
// registered, so they lag the scan state by exactly one clock.
//
// Optional feature, enabled by defining SEG_LEADING_ZERO_BLANK_EN:
//   leading-zero blanking. A digit above digit 0 whose nibble and all higher
//   nibbles are zero, and which has no decimal point requested, keeps its
//   time slot but holds its anode off. With the macro undefined, no blanking
//   logic is built.

module seg_scan_mux #(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_CYC   = 1000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic [4*NUM_DIGITS-1:0]       digit_data,
    input  logic [NUM_DIGITS-1:0]         digit_en,
    input  logic [NUM_DIGITS-1:0]         dp_in,
    output logic [NUM_DIGITS-1:0]         anode,
    output logic [6:0]                    seg,
    output logic                          dp,
    output logic [$clog2(NUM_DIGITS)-1:0] scan_idx,
    output logic                          frame_tick
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    localparam logic [CNT_W-1:0] CNT_TC   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    // Active-low segment pattern for one hex nibble, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Scan state
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;

    // Registered pin drives
    logic [NUM_DIGITS-1:0] anode_q, anode_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic                  frame_tick_q, frame_tick_d;

    // Per-slot selections from the live inputs
    logic [NUM_DIGITS-1:0] lz_blank;
    logic [NUM_DIGITS-1:0] anode_sel;
    logic [3:0]            cur_nib;
    logic                  cur_en;
    logic                  cur_dp;
    logic                  cur_lz;
    logic                  past_blank;
    logic                  digit_on;

    // Blank window: anodes stay off while cnt is still inside the first
    // BLANK_CYC cycles of the slot. A zero window needs no comparator.
    generate
        if (BLANK_CYC == 0) begin : g_no_blank
            assign past_blank = 1'b1;
        end else begin : g_blank
            assign past_blank = (cnt_q >= CNT_W'(BLANK_CYC));
        end
    endgenerate

`ifdef SEG_LEADING_ZERO_BLANK_EN
    logic zeros_above;

    // Walk from the most significant digit down; a digit is a leading zero
    // while everything from it upward is zero. Digit 0 always shows.
    always_comb begin
        lz_blank    = '0;
        zeros_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zeros_above = zeros_above & (digit_data[4*i +: 4] == 4'h0);
            lz_blank[i] = zeros_above & ~dp_in[i];
        end
    end
`else
    assign lz_blank = '0;
`endif

    // Prescaler: cnt counts cycles within a slot, idx advances on terminal
    // count and wraps explicitly so non-power-of-two digit counts never
    // reach an unused index. Everything holds while en is low.
    always_comb begin
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        frame_tick_d = 1'b0;
        if (en) begin
            if (cnt_q == CNT_TC) begin
                cnt_d = '0;
                if (idx_q == IDX_LAST) begin
                    idx_d        = '0;
                    frame_tick_d = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Slot mux: pick the current digit's nibble, enables and anode pattern.
    always_comb begin
        cur_nib   = 4'h0;
        cur_en    = 1'b0;
        cur_dp    = 1'b0;
        cur_lz    = 1'b0;
        anode_sel = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_nib      = digit_data[4*i +: 4];
                cur_en       = digit_en[i];
                cur_dp       = dp_in[i];
                cur_lz       = lz_blank[i];
                anode_sel[i] = 1'b0;
            end
        end
    end

    // Next pin values. Disabled or blanked digits still use their slot,
    // only the anode is suppressed, so brightness stays uniform.
    always_comb begin
        digit_on = en & cur_en & past_blank & ~cur_lz;
        anode_d  = digit_on ? anode_sel : '1;
        seg_d    = en ? hex_to_seg(cur_nib) : 7'h7F;
        dp_d     = ~(en & cur_dp);
    end

    // State and pin registers; reset blanks the display without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            anode_q      <= '1;
            seg_q        <= 7'h7F;
            dp_q         <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            anode_q      <= anode_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign anode      = anode_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_tick = frame_tick_q;
    assign scan_idx   = idx_q;

endmodule

// File: doc/seg_scan_mux.md
Name: seg_scan_mux

Overview:
- Parametrised, time-multiplexed seven-segment display driver. Replaces the fixed combinational anode select.
- A free-running refresh prescaler walks a digit index across NUM_DIGITS anodes.
- Per-slot hex decode, per-digit enable and decimal point, an anti-ghosting blank window, and a frame pulse.
- Sits between the UART receive datapath (hex nibble register) and the board display pins.

Parameters:
- NUM_DIGITS, 8, number of digits/anodes; legal 2..16.
- REFRESH_DIV, 100000, clock cycles per digit slot; must be greater than BLANK_CYC.
- BLANK_CYC, 1000, cycles at the start of each slot with all anodes off; 0 = no blanking.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  scan enable; low freezes the scan and blanks the display.
- digit_data  input  4*NUM_DIGITS  hex nibbles; nibble i = digit_data[4i+3:4i]; digit 0 is rightmost.
- digit_en  input  NUM_DIGITS  per-digit enable; 0 keeps that anode off.
- dp_in  input  NUM_DIGITS  per-digit decimal point request, active-high.
- anode  output  NUM_DIGITS  anode drives, active-low, at most one bit low.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low.
- scan_idx  output  $clog2(NUM_DIGITS)  current slot index (state register, not delayed).
- frame_tick  output  1  one-cycle pulse when the index wraps to 0.

Behaviour:
- One clock domain. Reset is asynchronous, active-low, on rst_n; all registers are clocked by clk.
- Reset values:
  - Internal: cnt=0, idx=0.
  - Outputs: anode all 1s, seg=7'h7F, dp=1, frame_tick=0, scan_idx=0.
  - Asserting rst_n mid-scan blanks the outputs immediately, with no clock edge required.
- Prescaler, evaluated each posedge with en=1:
  - If cnt==REFRESH_DIV-1: cnt←0; idx←(idx==NUM_DIGITS-1)?0:idx+1; frame_tick←(idx==NUM_DIGITS-1).
  - Else: cnt←cnt+1; frame_tick←0.
- Frame period is NUM_DIGITS*REFRESH_DIV cycles. Disabled digits still consume their slot, so brightness stays uniform.
- Output register, updated every posedge from the current (cnt, idx):
  - on = en & digit_en[idx] & (cnt>=BLANK_CYC) & !lz_blank[idx].
  - anode ← on ? ~(1<<idx) : all 1s.
  - seg ← en ? decode(nibble idx) : 7'h7F.
  - dp ← ~(en & dp_in[idx]).
  - Latency: exactly 1 cycle from the state registers to the pins.
  - Inputs are sampled live each cycle; changes appear on the pins one cycle later.
- Decode table (active-low hex): 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E.
- en low:
  - cnt, idx and scan_idx hold; frame_tick=0.
  - Next edge: anode all 1s, seg 7F, dp 1.
  - Re-asserting en resumes from the held cnt/idx with no restart.
- Without the optional feature, lz_blank is all 0s.
- Arithmetic:
  - cnt width is $clog2(REFRESH_DIV); wraps only via the compare, never by overflow.
  - For non-power-of-two NUM_DIGITS, idx never takes a value ≥ NUM_DIGITS.
- Simultaneous events: en falling on the terminal-count edge means no advance; idx holds.

Optional Feature:
- Macro: SEG_LEADING_ZERO_BLANK_EN.
- Defined: lz_blank[i]=1 when all of the following hold:
  - i>0;
  - nibble i==0 and every nibble j>i ==0;
  - dp_in[i]==0.
- Blanked digits keep their time slot with the anode held off. Digit 0 is never blanked. lz_blank is computed combinationally from the live inputs and feeds the output register.
- Undefined: lz_blank tied to 0 and no extra logic is generated.

Test Plan:
- Bench params for all scenarios: NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYC=2.
1. Reset: hold rst_n=0 with clocks running → anode=4'hF, seg=7'h7F, dp=1, frame_tick=0, scan_idx=0.
2. Basic scan: release reset with en=1, digit_data=16'h3210, digit_en=4'hF, dp_in=0.
   - anode=4'hE with seg=40 on cycles 3..8 after release; 4'hF on cycles 1..2.
   - Then 4'hD/seg 79, 4'hB/seg 24, 4'h7/seg 30.
   - frame_tick high for one cycle every 32 cycles.
3. Digit enable and decimal point: digit_en=4'b1011, dp_in=4'b0001.
   - Slot 2: anode stays 4'hF for all 8 cycles.
   - Frame period stays 32 cycles.
   - dp=0 only during slot 0.
4. en pause: drop en at slot 1, cnt=5; hold low 10 cycles; re-raise.
   - Next edge: anode=4'hF, seg=7F.
   - scan_idx stays 1 throughout.
   - After re-raise, anode=4'hD for 3 more cycles, then slot 2.
5. Async reset mid-scan: assert rst_n=0 between edges during slot 3 → anode=4'hF, seg=7'h7F immediately; on release, scanning restarts at slot 0 with cnt=0.
6. With SEG_LEADING_ZERO_BLANK_EN defined:
   - digit_data=16'h0050 → slots 3 and 2 are 4'hF; slot 1 shows seg 12; slot 0 shows seg 40.
   - Set dp_in=4'b0100 → slot 2 is driven with seg 40 and dp=0.
